wb_serial_master: RTL and testbench
===================================

WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

Interface
REQ-001 Parameter: TIMEOUT, default 1024, cycles to wait for ack_i before abandoning a bus cycle (range 2..65535).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 rx_data  input  8  command byte from serial receiver.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  byte accepted on a clk edge where rx_valid & rx_ready.
REQ-007 tx_data  output  8  response byte to serial transmitter.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  byte consumed on a clk edge where tx_valid & tx_ready.
REQ-010 adr_o  output  16  Wishbone address.
REQ-011 dat_o  output  32  Wishbone write data.
REQ-012 dat_i  input  32  Wishbone read data.
REQ-013 we_o  output  1  Wishbone write enable.
REQ-014 sel_o  output  4  Wishbone byte select.
REQ-015 stb_o, cyc_o  output  1 each  Wishbone strobe / cycle.
REQ-016 ack_i  input  1  Wishbone acknowledge.

Function
REQ-017 Block SHALL be a Wishbone initiator driven by a byte command stream; states IDLE, ADDR, DATA, BUS, RESP.
REQ-018 Frame: cmd byte, adr[15:8], adr[7:0], then for writes 4 data bytes MSB first; cmd 0x57 ('W') = write, 0x52 ('R') = read.
REQ-019 rx_ready SHALL be 1 only in IDLE, ADDR, DATA; 0 in BUS and RESP (no byte dropped, no buffering beyond frame registers).
REQ-020 IDLE: accepted 0x57/0x52 -> ADDR (byte counter cleared); any other byte -> RESP with single response 0x3F ('?').
REQ-021 ADDR: after 2nd address byte -> DATA if write, BUS if read; DATA: after 4th data byte -> BUS.
REQ-022 BUS entry: cyc_o=stb_o=1 from the cycle after the last frame byte is accepted; adr_o, dat_o, we_o stable for whole cycle; sel_o=4'hF while cyc_o, 4'h0 otherwise.
REQ-023 ack_i sampled 1 while cyc_o: next cycle cyc_o=stb_o=0; read data latched from dat_i on that same edge; -> RESP.
REQ-024 ack_i while cyc_o=0 SHALL be ignored.
REQ-025 Timeout counter clears on BUS entry, increments each cycle without ack; at TIMEOUT cycles without ack, drop cyc_o/stb_o, response 0x54 ('T'); late ack ignored.
REQ-026 Responses: write success 0x4B ('K'); read success 0x4B then data[31:24], [23:16], [15:8], [7:0]; timeout/bad cmd single byte as above.
REQ-027 RESP: tx_valid=1, tx_data held stable until tx_ready; advance one byte per handshake; after last byte -> IDLE next cycle.
REQ-028 ack_i and timeout expiring on the same edge: ack wins (success response).
REQ-029 Back-to-back frames: new cmd byte accepted earliest one cycle after last response handshake.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, tx_valid=0, tx_data=0, rx_ready=0; counters and read-data latch 0.
REQ-031 First cycle after rst deasserts: rx_ready=1; reset mid-frame, mid-bus-cycle or mid-response discards all progress, no response emitted.

Verification
REQ-032 Write: bytes 57 12 34 DE AD BE EF, slave acks after 3 cycles -> adr_o=0x1234, dat_o=0xDEADBEEF, we_o=1, sel_o=F, single ack; tx emits 4B.
REQ-033 Read: bytes 52 00 10, slave acks with dat_i=0xCAFEF00D -> we_o=0, tx emits 4B CA FE F0 0D in order.
REQ-034 Timeout: TIMEOUT=16, read with no ack -> cyc_o falls after 16 cycles, tx emits 54; later ack_i pulse has no effect.
REQ-035 Bad cmd 41 -> no bus cycle, tx emits 3F, then valid 52 frame completes normally.
REQ-036 Backpressure: tx_ready low 10 cycles during read response -> tx_data/tx_valid stable, rx_ready=0, no byte lost or repeated.
REQ-037 Reset: rst=0 while cyc_o=1 -> cyc_o/stb_o drop asynchronously, no response byte after release, next frame works.

Source files
------------

// File: rtl/wb_serial_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_serial_master_if
// Purpose  : Byte-stream handshakes plus Wishbone initiator signals.
// Revision : 1.0
// ============================================================================
interface wb_serial_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    modport master (
        input  rx_data, rx_valid, tx_ready, dat_i, ack_i,
        output rx_ready, tx_data, tx_valid, adr_o, dat_o, we_o, sel_o, stb_o, cyc_o
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dat_i, ack_i,
        input  rx_ready, tx_data, tx_valid, adr_o, dat_o, we_o, sel_o, stb_o, cyc_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_serial_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_serial_master
// Purpose  : Wishbone initiator driven by 'W'/'R' byte command frames.
// Revision : 1.0
// ============================================================================
module wb_serial_master #(
    parameter int TIMEOUT = 1024
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    wb_serial_master_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [7:0]  CMD_WR  = 8'h57;
    localparam logic [7:0]  CMD_RD  = 8'h52;
    localparam logic [7:0]  RSP_OK  = 8'h4B;
    localparam logic [7:0]  RSP_TO  = 8'h54;
    localparam logic [7:0]  RSP_BAD = 8'h3F;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [15:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  code_q, code_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  last_q, last_d;

    logic        rx_ready_w;
    logic        rx_hs_w;
    logic        tx_hs_w;
    logic        cyc_w;

    // Ready is gated by the reset pin so it reads 0 while reset is held.
    assign rx_ready_w = rst_n & ((state_q == S_IDLE) | (state_q == S_ADDR) |
                                 (state_q == S_DATA));
    assign rx_hs_w    = bus.rx_valid & rx_ready_w;
    assign tx_hs_w    = (state_q == S_RESP) & bus.tx_ready;
    assign cyc_w      = (state_q == S_BUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= 2'd0;
            adr_q   <= 16'h0;
            dat_q   <= 32'h0;
            we_q    <= 1'b0;
            tcnt_q  <= 16'h0;
            rdata_q <= 32'h0;
            code_q  <= 8'h0;
            pos_q   <= 3'd0;
            last_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            tcnt_q  <= tcnt_d;
            rdata_q <= rdata_d;
            code_q  <= code_d;
            pos_q   <= pos_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;
        code_d  = code_q;
        pos_d   = pos_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (rx_hs_w) begin
                    bcnt_d = 2'd0;
                    if (bus.rx_data == CMD_WR) begin
                        we_d    = 1'b1;
                        state_d = S_ADDR;
                    end else if (bus.rx_data == CMD_RD) begin
                        we_d    = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        code_d  = RSP_BAD;
                        pos_d   = 3'd0;
                        last_d  = 3'd0;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_hs_w) begin
                    adr_d  = {adr_q[7:0], bus.rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd1) begin
                        bcnt_d  = 2'd0;
                        tcnt_d  = 16'h0;
                        state_d = we_q ? S_DATA : S_BUS;
                    end
                end
            end
            S_DATA: begin
                if (rx_hs_w) begin
                    dat_d  = {dat_q[23:0], bus.rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        tcnt_d  = 16'h0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.ack_i) begin
                    rdata_d = bus.dat_i;
                    code_d  = RSP_OK;
                    pos_d   = 3'd0;
                    last_d  = we_q ? 3'd0 : 3'd4;
                    state_d = S_RESP;
                end else if (tcnt_q == TO_LAST) begin
                    code_d  = RSP_TO;
                    pos_d   = 3'd0;
                    last_d  = 3'd0;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (tx_hs_w) begin
                    if (pos_q == last_q) begin
                        pos_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_data = code_q;
        case (pos_q)
            3'd1:    bus.tx_data = rdata_q[31:24];
            3'd2:    bus.tx_data = rdata_q[23:16];
            3'd3:    bus.tx_data = rdata_q[15:8];
            3'd4:    bus.tx_data = rdata_q[7:0];
            default: bus.tx_data = code_q;
        endcase
    end

    assign bus.rx_ready = rx_ready_w;
    assign bus.tx_valid = (state_q == S_RESP);
    assign bus.adr_o    = adr_q;
    assign bus.dat_o    = dat_q;
    assign bus.we_o     = we_q & cyc_w;
    assign bus.sel_o    = cyc_w ? 4'hF : 4'h0;
    assign bus.stb_o    = cyc_w;
    assign bus.cyc_o    = cyc_w;

endmodule
`default_nettype wire

// File: tb/tb_wb_serial_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_serial_master
// Purpose  : Scoreboard bench for wb_serial_master with a simple Wishbone slave.
// Revision : 1.0
// ============================================================================
module tb_wb_serial_master;

    localparam int TO = 16;

    typedef struct packed {
        logic [15:0] adr;
        logic [31:0] dat;
        logic        we;
    } bus_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_serial_master_if u_if();

    wb_serial_master #(.TIMEOUT(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] tx_q[$];
    bus_t       bus_q[$];

    logic        slv_ack   = 1'b0;
    logic        late_ack  = 1'b0;
    logic [31:0] slv_dat   = 32'h0;
    logic [31:0] rd_val    = 32'h0;
    int          slv_delay = 0;
    bit          slv_en    = 1'b1;
    int          scnt      = 0;
    logic        tx_rdy    = 1'b1;

    assign u_if.ack_i    = slv_ack | late_ack;
    assign u_if.dat_i    = slv_dat;
    assign u_if.tx_ready = tx_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: acks slv_delay cycles into the bus cycle, one-cycle pulse.
    always begin
        @(posedge clk);
        #1;
        if (u_if.cyc_o) begin
            if (slv_en && scnt == slv_delay) begin
                slv_ack = 1'b1;
                slv_dat = rd_val;
            end else begin
                slv_ack = 1'b0;
            end
            scnt++;
        end else begin
            slv_ack = 1'b0;
            scnt    = 0;
        end
    end

    // Response monitor: every tx handshake pops the scoreboard.
    always @(negedge clk) begin : m_tx
        logic [7:0] e;
        if (rst_n && u_if.tx_valid && u_if.tx_ready) begin
            if (tx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", u_if.tx_data);
            end else begin
                e = tx_q.pop_front();
                check("tx_byte", {24'h0, u_if.tx_data}, {24'h0, e});
            end
        end
    end

    // Bus monitor: every acked cycle pops the expected transaction.
    logic        cyc_prev  = 1'b0;
    logic [15:0] adr_first = 16'h0;
    logic [31:0] dat_first = 32'h0;
    logic        we_first  = 1'b0;

    always @(negedge clk) begin : m_bus
        bus_t e;
        if (u_if.cyc_o && !cyc_prev) begin
            adr_first = u_if.adr_o;
            dat_first = u_if.dat_o;
            we_first  = u_if.we_o;
        end
        if (rst_n && u_if.cyc_o && u_if.ack_i) begin
            if (bus_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_unexpected: got cycle at 0x%0h expected none", u_if.adr_o);
            end else begin
                e = bus_q.pop_front();
                check("bus_adr", {16'h0, u_if.adr_o}, {16'h0, e.adr});
                check("bus_we", {31'h0, u_if.we_o}, {31'h0, e.we});
                check("bus_sel", {28'h0, u_if.sel_o}, 32'hF);
                check("bus_stb", {31'h0, u_if.stb_o}, 32'h1);
                if (e.we) check("bus_dat", u_if.dat_o, e.dat);
                check("bus_adr_stable", {16'h0, u_if.adr_o}, {16'h0, adr_first});
                check("bus_dat_stable", u_if.dat_o, dat_first);
                check("bus_we_stable", {31'h0, u_if.we_o}, {31'h0, we_first});
            end
        end
        cyc_prev = u_if.cyc_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit hs;
        hs = 1'b0;
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            hs = u_if.rx_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        u_if.rx_valid = 1'b0;
        if (!hs) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_accept: got stall expected byte 0x%0h accepted", b);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (tx_q.size() == 0 && bus_q.size() == 0 && !u_if.tx_valid && !u_if.cyc_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no completion expected idle within 300 cycles", name);
        end
    endtask

    task automatic read_frame(input logic [15:0] a, input logic [31:0] d);
        rd_val = d;
        bus_q.push_back('{adr: a, dat: 32'h0, we: 1'b0});
        tx_q.push_back(8'h4B);
        tx_q.push_back(d[31:24]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
        send_byte(8'h52);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic write_frame(input logic [15:0] a, input logic [31:0] d);
        bus_q.push_back('{adr: a, dat: d, we: 1'b1});
        tx_q.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    initial begin : m_stim
        int  cnt;
        bit  stable;
        u_if.rx_data  = 8'h0;
        u_if.rx_valid = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_cyc", {31'h0, u_if.cyc_o}, 32'h0);
        check("rst_stb", {31'h0, u_if.stb_o}, 32'h0);
        check("rst_we", {31'h0, u_if.we_o}, 32'h0);
        check("rst_sel", {28'h0, u_if.sel_o}, 32'h0);
        check("rst_adr", {16'h0, u_if.adr_o}, 32'h0);
        check("rst_dat", u_if.dat_o, 32'h0);
        check("rst_tx_valid", {31'h0, u_if.tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, u_if.tx_data}, 32'h0);
        check("rst_rx_ready", {31'h0, u_if.rx_ready}, 32'h0);
        tick(3);
        check("rst_hold_rx_ready", {31'h0, u_if.rx_ready}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        check("post_rst_rx_ready", {31'h0, u_if.rx_ready}, 32'h1);

        // Write, ack after 3 cycles
        slv_delay = 3;
        write_frame(16'h1234, 32'hDEADBEEF);
        check("bus_entry_cyc", {31'h0, u_if.cyc_o}, 32'h1);
        check("bus_rx_ready", {31'h0, u_if.rx_ready}, 32'h0);
        wait_idle("write");

        // Read
        slv_delay = 2;
        read_frame(16'h0010, 32'hCAFEF00D);
        wait_idle("read");

        // Bad command, then a normal read
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        check("bad_no_cyc", {31'h0, u_if.cyc_o}, 32'h0);
        check("bad_tx_valid", {31'h0, u_if.tx_valid}, 32'h1);
        wait_idle("bad_cmd");
        slv_delay = 0;
        read_frame(16'hABCD, 32'h12345678);
        wait_idle("read_after_bad");

        // Timeout with no ack, then a stray late ack
        slv_en = 1'b0;
        tx_q.push_back(8'h54);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h20);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!u_if.cyc_o) break;
            cnt++;
        end
        check("timeout_len", 32'(cnt), 32'(TO));
        @(posedge clk);
        #1;
        wait_idle("timeout");
        late_ack = 1'b1;
        tick(1);
        late_ack = 1'b0;
        tick(3);
        check("late_ack_cyc", {31'h0, u_if.cyc_o}, 32'h0);
        check("late_ack_tx", {31'h0, u_if.tx_valid}, 32'h0);
        slv_en = 1'b1;

        // Ack on the same edge the timeout would expire
        slv_delay = TO - 1;
        read_frame(16'h0030, 32'h0BADF00D);
        wait_idle("ack_vs_timeout");

        // Backpressure on the response
        tx_rdy    = 1'b0;
        slv_delay = 0;
        read_frame(16'h0040, 32'hA1B2C3D4);
        for (int k = 0; k < 50; k++) begin
            if (u_if.tx_valid) break;
            tick(1);
        end
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (u_if.tx_data !== 8'h4B || u_if.tx_valid !== 1'b1 || u_if.rx_ready !== 1'b0)
                stable = 1'b0;
        end
        check("backpressure_stable", {31'h0, stable}, 32'h1);
        @(posedge clk);
        #1;
        tx_rdy = 1'b1;
        wait_idle("backpressure");

        // Reset in the middle of a bus cycle
        slv_en = 1'b0;
        send_byte(8'h57);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        check("pre_rst_cyc", {31'h0, u_if.cyc_o}, 32'h1);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc", {31'h0, u_if.cyc_o}, 32'h0);
        check("async_rst_stb", {31'h0, u_if.stb_o}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        check("rerst_rx_ready", {31'h0, u_if.rx_ready}, 32'h1);
        tick(30);
        check("rerst_no_tx", {31'h0, u_if.tx_valid}, 32'h0);
        slv_en    = 1'b1;
        slv_delay = 1;
        write_frame(16'h0001, 32'h11223344);
        wait_idle("write_after_reset");

        check("tx_queue_empty", 32'(tx_q.size()), 32'h0);
        check("bus_queue_empty", 32'(bus_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : m_watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
